send_recv_accum: RTL and testbench
==================================

Name: send_recv_accum

Overview:
- Stream stage placed directly downstream of the incrementer stage.
- Consumes its 32-bit en/rdy message stream and sums each consecutive group of nmsgs messages.
- Emits one sum message per group, with a sticky overflow flag, on an en/rdy send interface.
- Used as the sink-side reduction stage in source/sink test harnesses and in datapaths that checksum message bursts.

Parameters:
- nbits, 32: message and sum width.
- nmsgs, 4: messages per group; legal range 1..256.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; asserted when 0.
- recv_rdy  output  1  stage can accept a message this cycle.
- recv_en  input  1  upstream transfers recv_msg this cycle; legal only while recv_rdy=1.
- recv_msg  input  nbits  incoming message.
- send_rdy  input  1  downstream can accept a message this cycle.
- send_en  output  1  stage transfers send_msg/send_ovfl this cycle.
- send_msg  output  nbits  group sum, modulo 2^nbits.
- send_ovfl  output  1  1 if any addition in the group carried out of bit nbits-1.

Behaviour:
- Handshake: a transfer occurs on a port in a cycle where its en=1. Senders assert en only when rdy=1. recv_en while recv_rdy=0 is a protocol violation; the message is ignored and state is unchanged.
- State: FSM {ACCUM, SEND}. Registers acc[nbits-1:0], ovfl, cnt[$clog2(nmsgs+1)-1:0].
- Reset (reset=0, asynchronous): state=ACCUM, acc=0, ovfl=0, cnt=0. While reset=0: recv_rdy=0, send_en=0, send_msg=0, send_ovfl=0.
- Any partial group is discarded on reset, including mid-group or while in SEND.
- ACCUM:
  - recv_rdy=1, send_en=0.
  - On recv_en: {carry, acc} = acc + recv_msg (nbits+1-bit add); ovfl |= carry; cnt++.
  - If the accepted message is the nmsgs-th (cnt==nmsgs-1 before the increment), move to SEND next cycle.
- SEND:
  - send_en = send_rdy; send_msg = acc; send_ovfl = ovfl. Outputs are held stable until the transfer.
  - recv_rdy = send_rdy (overlap path).
  - If send_rdy=0: stay in SEND, recv_rdy=0.
  - If send_rdy=1 and recv_en=0: acc=0, ovfl=0, cnt=0, go to ACCUM.
  - If send_rdy=1 and recv_en=1 (simultaneous event): the new message starts the next group. acc=recv_msg, ovfl=0, cnt=1. Go to ACCUM, or stay in SEND if nmsgs==1.
- Outputs when send_en=0: send_msg=0, send_ovfl=0.
- Latency: the sum is presented in the cycle after the last message of the group is accepted.
- Throughput: one message per cycle sustained when send_rdy=1. No bubble, because of the overlap path.
- nmsgs=1: every message is forwarded one cycle later, with send_ovfl=0.
- Combinational paths: recv_rdy depends on send_rdy. No path exists from recv_en or recv_msg to send_*.

Decomposition:
- Shared package send_recv_accum_pkg:
  - typedef enum logic {ACCUM, SEND} state_t.
  - Localparam helper for counter width.
- One sub-module, send_recv_accum_dpath: acc, ovfl, cnt registers; carry-out adder; last-message compare. It takes control signals acc_clr, acc_load, acc_add and returns is_last.
- The FSM and the en/rdy logic live in the top module.

Test Plan:
- Basic (nmsgs=4): send 1,2,3,4 with send_rdy=1 → exactly one send with send_msg=10, send_ovfl=0, one cycle after 4 is accepted.
- Overflow: send 0xFFFFFFFF,0x00000002,0,0 → send_msg=0x00000001, send_ovfl=1. Next group 1,1,1,1 → 4 with send_ovfl=0 (flag cleared).
- Backpressure: complete group 5,5,5,5, then hold send_rdy=0 for 3 cycles → send_en=0 and recv_rdy=0 for those cycles, send_msg held internally. On send_rdy=1, exactly one transfer of 20 occurs.
- Overlap: back-to-back stream 1..8 with source and sink always ready → sums 10 and 26 with no idle cycle. The 5 is accepted in the same cycle the 10 is sent.
- Reset mid-group: accept 7,9, then drive reset=0 asynchronously between edges → recv_rdy and send_en drop immediately. After release, send 5,6,7,8 → send_msg=26 (partial sum discarded).
- Random delays: source/sink with random 0–3 cycle stalls, 40 random messages, nmsgs=1 and nmsgs=4 builds → every group sum matches the reference model, with no drops or duplicates.

Source files
------------

// File: rtl/send_recv_accum_pkg.sv
// Shared definitions for the send_recv_accum stream reduction stage.
//   state_t   : two-state control FSM (collecting a group / presenting its sum)
//   cnt_width : width of the in-group message counter for a given group size
package send_recv_accum_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        SEND  = 1'b1
    } state_t;

    // The counter must be able to hold nmsgs itself, so size it for n+1 values.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/send_recv_accum_dpath.sv
// Datapath of send_recv_accum: running sum, sticky carry flag and group counter.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   i_acc_clr      : clear sum, flag and counter (group handed off, nothing new)
//   i_acc_load     : start a new group with i_msg (sum handed off in same cycle)
//   i_acc_add      : add i_msg into the running sum
//   i_msg          : incoming message
//   o_acc, o_ovfl  : current sum (mod 2^nbits) and sticky carry-out flag
//   o_is_last      : the next accepted message completes the group
module send_recv_accum_dpath
    import send_recv_accum_pkg::*;
#(
    parameter int nbits = 32,
    parameter int nmsgs = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_acc_clr,
    input  logic             i_acc_load,
    input  logic             i_acc_add,
    input  logic [nbits-1:0] i_msg,
    output logic [nbits-1:0] o_acc,
    output logic             o_ovfl,
    output logic             o_is_last
);

    localparam int            CW   = cnt_width(nmsgs);
    localparam logic [CW-1:0] LAST = CW'(nmsgs - 1);

    logic [nbits-1:0] r_acc;
    logic             r_ovfl;
    logic [CW-1:0]    r_cnt;
    logic [nbits:0]   w_sum;

    // One extra bit captures the carry out of the top of the sum.
    assign w_sum = {1'b0, r_acc} + {1'b0, i_msg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_ovfl <= 1'b0;
            r_cnt  <= '0;
        end else if (i_acc_load) begin
            r_acc  <= i_msg;
            r_ovfl <= 1'b0;
            r_cnt  <= CW'(1);
        end else if (i_acc_clr) begin
            r_acc  <= '0;
            r_ovfl <= 1'b0;
            r_cnt  <= '0;
        end else if (i_acc_add) begin
            r_acc  <= w_sum[nbits-1:0];
            r_ovfl <= r_ovfl | w_sum[nbits];
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_acc     = r_acc;
    assign o_ovfl    = r_ovfl;
    assign o_is_last = (r_cnt == LAST);

endmodule

// File: rtl/send_recv_accum.sv
// Stream reduction stage: sums each consecutive group of nmsgs messages from an
// en/rdy receive port and emits one sum (with sticky carry flag) per group on
// an en/rdy send port. A new group may begin in the same cycle the previous
// sum is handed off, so a fully ready stream runs without bubbles.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   recv_rdy/recv_en    : receive handshake; recv_msg is the incoming message
//   send_rdy/send_en    : send handshake; send_msg is the group sum,
//                         send_ovfl flags a carry out during the group
module send_recv_accum
    import send_recv_accum_pkg::*;
#(
    parameter int nbits = 32,
    parameter int nmsgs = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             recv_rdy,
    input  logic             recv_en,
    input  logic [nbits-1:0] recv_msg,
    input  logic             send_rdy,
    output logic             send_en,
    output logic [nbits-1:0] send_msg,
    output logic             send_ovfl
);

    state_t           r_state;
    state_t           w_next;
    logic             w_recv_rdy;
    logic             w_send_en;
    logic             w_clr;
    logic             w_load;
    logic             w_add;
    logic             w_is_last;
    logic [nbits-1:0] w_acc;
    logic             w_ovfl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_recv_rdy = 1'b0;
        w_send_en  = 1'b0;
        w_clr      = 1'b0;
        w_load     = 1'b0;
        w_add      = 1'b0;
        case (r_state)
            ACCUM: begin
                w_recv_rdy = 1'b1;
                if (recv_en) begin
                    w_add = 1'b1;
                    if (w_is_last) begin
                        w_next = SEND;
                    end
                end
            end
            SEND: begin
                // Receive is only open while the sum is leaving, so the
                // incoming message can seed the next group directly.
                w_recv_rdy = send_rdy;
                w_send_en  = send_rdy;
                if (send_rdy) begin
                    if (recv_en) begin
                        w_load = 1'b1;
                        w_next = (nmsgs == 1) ? SEND : ACCUM;
                    end else begin
                        w_clr  = 1'b1;
                        w_next = ACCUM;
                    end
                end
            end
            default: w_next = ACCUM;
        endcase
    end

    send_recv_accum_dpath #(
        .nbits (nbits),
        .nmsgs (nmsgs)
    ) u_dpath (
        .clk        (clk),
        .reset      (reset),
        .i_acc_clr  (w_clr),
        .i_acc_load (w_load),
        .i_acc_add  (w_add),
        .i_msg      (recv_msg),
        .o_acc      (w_acc),
        .o_ovfl     (w_ovfl),
        .o_is_last  (w_is_last)
    );

    // Handshake outputs are forced low for as long as reset is held, not just
    // until the next edge.
    assign recv_rdy  = w_recv_rdy & reset;
    assign send_en   = w_send_en & reset;
    assign send_msg  = send_en ? w_acc : '0;
    assign send_ovfl = send_en & w_ovfl;

endmodule

// File: tb/tb_send_recv_accum.sv
module tb_send_recv_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a   [2];
    logic [31:0] msg_a  [2];
    logic        srdy_a [2];
    logic        rrdy_a [2];
    logic        sen_a  [2];
    logic [31:0] smsg_a [2];
    logic        sovfl_a[2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    send_recv_accum #(.nbits(32), .nmsgs(4)) u_dut4 (
        .clk(clk), .reset(rst_n),
        .recv_rdy(rrdy_a[0]), .recv_en(en_a[0]), .recv_msg(msg_a[0]),
        .send_rdy(srdy_a[0]), .send_en(sen_a[0]), .send_msg(smsg_a[0]), .send_ovfl(sovfl_a[0])
    );

    send_recv_accum #(.nbits(32), .nmsgs(1)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .recv_rdy(rrdy_a[1]), .recv_en(en_a[1]), .recv_msg(msg_a[1]),
        .send_rdy(srdy_a[1]), .send_en(sen_a[1]), .send_msg(smsg_a[1]), .send_ovfl(sovfl_a[1])
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents four messages to the nmsgs=4 instance on consecutive cycles.
    task automatic feed4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e);
        logic [31:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = e;
        for (int i = 0; i < 4; i++) begin
            en_a[0]  = 1'b1;
            msg_a[0] = v[i];
            #1;
            n_cmp++;
            if (rrdy_a[0] !== 1'b1 || sen_a[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL feed4_accept[%0d]: recv_rdy=%b send_en=%b want 1/0", i, rrdy_a[0], sen_a[0]);
            end
            cyc();
        end
        en_a[0] = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (rrdy_a[0] !== 1'b0 || sen_a[0] !== 1'b0 || smsg_a[0] !== 32'd0 || sovfl_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b en=%b msg=%h ovfl=%b want 0/0/0/0",
                     rrdy_a[0], sen_a[0], smsg_a[0], sovfl_a[0]);
        end
        n_cmp++;
        if (rrdy_a[1] !== 1'b0 || sen_a[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs_n1: rdy=%b en=%b want 0/0", rrdy_a[1], sen_a[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (rrdy_a[0] !== 1'b1 || rrdy_a[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_rdy: got %b/%b want 1/1", rrdy_a[0], rrdy_a[1]);
        end
        cyc();
    endtask

    task automatic test_basic();
        srdy_a[0] = 1'b1;
        feed4(32'd1, 32'd2, 32'd3, 32'd4);
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== 32'd10 || sovfl_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_sum: en=%b msg=%0d ovfl=%b want 1/10/0", sen_a[0], smsg_a[0], sovfl_a[0]);
        end
        cyc();
        n_cmp++;
        if (sen_a[0] !== 1'b0 || smsg_a[0] !== 32'd0 || rrdy_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_single_send: en=%b msg=%0d rdy=%b want 0/0/1", sen_a[0], smsg_a[0], rrdy_a[0]);
        end
    endtask

    task automatic test_overflow();
        srdy_a[0] = 1'b1;
        feed4(32'hFFFF_FFFF, 32'h0000_0002, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== 32'h0000_0001 || sovfl_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL ovfl_sum: en=%b msg=%h ovfl=%b want 1/00000001/1", sen_a[0], smsg_a[0], sovfl_a[0]);
        end
        cyc();
        feed4(32'd1, 32'd1, 32'd1, 32'd1);
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== 32'd4 || sovfl_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL ovfl_cleared: en=%b msg=%0d ovfl=%b want 1/4/0", sen_a[0], smsg_a[0], sovfl_a[0]);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        srdy_a[0] = 1'b1;
        feed4(32'd5, 32'd5, 32'd5, 32'd5);
        srdy_a[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (sen_a[0] !== 1'b0 || rrdy_a[0] !== 1'b0 || smsg_a[0] !== 32'd0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: en=%b rdy=%b msg=%0d want 0/0/0", i, sen_a[0], rrdy_a[0], smsg_a[0]);
            end
            cyc();
        end
        srdy_a[0] = 1'b1;
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== 32'd20 || sovfl_a[0] !== 1'b0 || rrdy_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: en=%b msg=%0d ovfl=%b rdy=%b want 1/20/0/1",
                     sen_a[0], smsg_a[0], sovfl_a[0], rrdy_a[0]);
        end
        cyc();
        n_cmp++;
        if (sen_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_one_transfer: en=%b want 0", sen_a[0]);
        end
    endtask

    task automatic test_back_to_back();
        longint grp;
        logic [31:0] prev;
        srdy_a[0] = 1'b1;
        grp  = 0;
        prev = 32'd0;
        for (int k = 0; k < 8; k++) begin
            en_a[0]  = 1'b1;
            msg_a[0] = 32'(k + 1);
            #1;
            n_cmp++;
            if (rrdy_a[0] !== 1'b1 || sen_a[0] !== (k == 4) || (k == 4 && smsg_a[0] !== prev)) begin
                n_bad++;
                $display("FAIL b2b_cycle[%0d]: rdy=%b en=%b msg=%0d want 1/%b/%0d",
                         k, rrdy_a[0], sen_a[0], smsg_a[0], (k == 4), (k == 4) ? prev : 32'd0);
            end
            grp = grp + (k + 1);
            if ((k % 4) == 3) begin
                prev = grp[31:0];
                grp  = 0;
            end
            cyc();
        end
        en_a[0] = 1'b0;
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== prev || prev !== 32'd26) begin
            n_bad++;
            $display("FAIL b2b_second: en=%b msg=%0d want 1/26", sen_a[0], smsg_a[0]);
        end
        cyc();
        n_cmp++;
        if (sen_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: en=%b want 0", sen_a[0]);
        end
    endtask

    task automatic test_reset_mid();
        srdy_a[0] = 1'b1;
        en_a[0] = 1'b1; msg_a[0] = 32'd7; cyc();
        msg_a[0] = 32'd9; cyc();
        en_a[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rrdy_a[0] !== 1'b0 || sen_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_drop: rdy=%b en=%b want 0/0", rrdy_a[0], sen_a[0]);
        end
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (rrdy_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_release: rdy=%b want 1", rrdy_a[0]);
        end
        cyc();
        feed4(32'd5, 32'd6, 32'd7, 32'd8);
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== 32'd26 || sovfl_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_discard: en=%b msg=%0d ovfl=%b want 1/26/0", sen_a[0], smsg_a[0], sovfl_a[0]);
        end
        cyc();
        // Reset while a finished sum is waiting: it must be dropped.
        srdy_a[0] = 1'b0;
        feed4(32'd1, 32'd1, 32'd1, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        srdy_a[0] = 1'b1;
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b0 || smsg_a[0] !== 32'd0 || rrdy_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_send_drop: en=%b msg=%0d rdy=%b want 0/0/0", sen_a[0], smsg_a[0], rrdy_a[0]);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b0 || rrdy_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_send_release: en=%b rdy=%b want 0/1", sen_a[0], rrdy_a[0]);
        end
        cyc();
        feed4(32'd2, 32'd2, 32'd2, 32'd2);
        #1;
        n_cmp++;
        if (sen_a[0] !== 1'b1 || smsg_a[0] !== 32'd8 || sovfl_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_send_next: en=%b msg=%0d ovfl=%b want 1/8/0", sen_a[0], smsg_a[0], sovfl_a[0]);
        end
        cyc();
    endtask

    // Random source/sink stalls; expected sums come from grouping the sent
    // messages and adding them with 64-bit arithmetic (carry <=> total >= 2^32).
    task automatic test_random(input int d);
        int          nm, ngroups, sent, got, src_stall, snk_stall, grp_n;
        longint      grp_sum;
        logic [31:0] m, exp_m;
        logic        exp_o;
        logic [31:0] q_msg[$];
        logic        q_ovfl[$];
        nm        = (d == 0) ? 4 : 1;
        ngroups   = 40 / nm;
        sent      = 0;
        got       = 0;
        grp_n     = 0;
        grp_sum   = 0;
        src_stall = $urandom_range(0, 3);
        snk_stall = $urandom_range(0, 3);
        for (int c = 0; c < 2000 && got < ngroups; c++) begin
            cyc();
            if (snk_stall > 0) begin
                srdy_a[d] = 1'b0;
                snk_stall--;
            end else begin
                srdy_a[d] = 1'b1;
            end
            #1;
            en_a[d] = 1'b0;
            if (sent < 40) begin
                if (src_stall > 0) begin
                    src_stall--;
                end else if (rrdy_a[d] === 1'b1) begin
                    m = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 100));
                    en_a[d]  = 1'b1;
                    msg_a[d] = m;
                    sent++;
                    grp_sum = grp_sum + longint'(m);
                    grp_n++;
                    if (grp_n == nm) begin
                        q_msg.push_back(grp_sum[31:0]);
                        q_ovfl.push_back(grp_sum >= 64'h1_0000_0000);
                        grp_sum = 0;
                        grp_n   = 0;
                    end
                    src_stall = $urandom_range(0, 3);
                end
            end
            @(negedge clk);
            if (sen_a[d] === 1'b1) begin
                n_cmp++;
                if (q_msg.size() == 0) begin
                    n_bad++;
                    $display("FAIL rand%0d_extra: unexpected send msg=%h", nm, smsg_a[d]);
                end else begin
                    exp_m = q_msg.pop_front();
                    exp_o = q_ovfl.pop_front();
                    if (smsg_a[d] !== exp_m || sovfl_a[d] !== exp_o) begin
                        n_bad++;
                        $display("FAIL rand%0d_group[%0d]: msg=%h ovfl=%b want %h/%b",
                                 nm, got, smsg_a[d], sovfl_a[d], exp_m, exp_o);
                    end
                end
                got++;
                snk_stall = $urandom_range(0, 3);
            end
        end
        en_a[d] = 1'b0;
        n_cmp++;
        if (got != ngroups || sent != 40) begin
            n_bad++;
            $display("FAIL rand%0d_timeout: groups=%0d sent=%0d want %0d/40", nm, got, sent, ngroups);
        end
        srdy_a[d] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++;
            if (sen_a[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_dup: send_en=%b after all groups", nm, sen_a[d]);
            end
        end
        n_cmp++;
        if (q_msg.size() != 0) begin
            n_bad++;
            $display("FAIL rand%0d_drop: %0d sums never sent", nm, q_msg.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en_a[i]   = 1'b0;
            msg_a[i]  = 32'd0;
            srdy_a[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
